seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 105 ++++++++++
 tb/tb_seq_multiplier.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first.
// Ports: clk, rst (sync, active-high), in_valid/in_ready + a/b operand
// handshake, out_valid/out_ready + product result handshake, busy.
// MULT_SIGNED_EN: when defined, operands and product are two's complement.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic              last;
  logic [PW-1:0]     addend;

  // mcand_q is kept pre-shifted by the bit index and mplier_q shifted
  // right, so the current bit is always mplier_q[0].
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    last     = (cnt_q == CW'(WIDTH - 1));
    addend   = mplier_q[0] ? mcand_q : '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef MULT_SIGNED_EN
          mcand_d = {{WIDTH{a[WIDTH-1]}}, a};
`else
          mcand_d = {{WIDTH{1'b0}}, a};
`endif
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
`ifdef MULT_SIGNED_EN
        // b's MSB carries negative weight
        acc_d = last ? (acc_q - addend) : (acc_q + addend);
`else
        acc_d = acc_q + addend;
`endif
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed, backpressure,
// reset abort and randomized back-to-back traffic against a reference.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_s;
  logic [W-1:0]   b_s;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    longint sx, sy;
`ifdef MULT_SIGNED_EN
    sx = longint'($signed(x));
    sy = longint'($signed(y));
`else
    sx = longint'({1'b0, x});
    sy = longint'({1'b0, y});
`endif
    return (2*W)'(sx * sy);
  endfunction

  // One full operation from IDLE; hold = cycles of out_ready=0 in DONE.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                    input logic [2*W-1:0] exp, input int hold,
                    input string nm);
    a_s = ta;
    b_s = tb_v;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_s = W'($urandom);
    b_s = W'($urandom);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: busy=%b in_ready=%b required 1/0",
               nm, busy, in_ready);
    end
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      a_s = W'($urandom);
      b_s = W'($urandom);
      in_valid = (k < W) ? 1'($urandom) : 1'b0;
      n_cmp++;
      if (k < W) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s latency edge %0d: out_valid=%b required 0",
                   nm, k, out_valid);
        end
      end else if (out_valid !== 1'b1 || product !== exp) begin
        n_fail++;
        $display("FAIL %s result: out_valid=%b product=%h required 1/%h",
                 nm, out_valid, product, exp);
      end
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold %0d: ov=%b p=%h ir=%b required 1/%h/0",
                 nm, h, out_valid, product, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: ov=%b ir=%b busy=%b required 0/1/0",
               nm, out_valid, in_ready, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a_s = 4'h5;
    b_s = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        product !== '0) begin
      n_fail++;
      $display("FAIL reset: ir=%b busy=%b ov=%b p=%h required 1/0/0/00",
               in_ready, busy, out_valid, product);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: busy=%b required 0", busy);
    end
  endtask

  task automatic test_directed;
`ifdef MULT_SIGNED_EN
    op(4'h3, 4'h5, 8'h0F, 0, "mul_3x5");
    op(4'hF, 4'hF, 8'h01, 0, "mul_FxF");
    op(4'h8, 4'h7, 8'hC8, 0, "mul_8x7");
    op(4'h8, 4'h8, 8'h40, 0, "mul_8x8");
    op(4'hF, 4'h1, 8'hFF, 0, "mul_Fx1");
    op(4'h0, 4'h0, 8'h00, 0, "mul_0x0");
`else
    op(4'h3, 4'h5, 8'h0F, 0, "mul_3x5");
    op(4'hF, 4'hF, 8'hE1, 0, "mul_FxF");
    op(4'h8, 4'h7, 8'h38, 0, "mul_8x7");
    op(4'h8, 4'h8, 8'h40, 0, "mul_8x8");
    op(4'hF, 4'h1, 8'h0F, 0, "mul_Fx1");
    op(4'h0, 4'h0, 8'h00, 0, "mul_0x0");
`endif
  endtask

  task automatic test_backpressure;
    op(4'hB, 4'hD, ref_mul(4'hB, 4'hD), 10, "backpressure");
    op(4'h6, 4'h9, ref_mul(4'h6, 4'h9), 0, "after_bp");
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    a_s = 4'h9;
    b_s = 4'h7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        product !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: ir=%b busy=%b ov=%b p=%h required 1/0/0/00",
               in_ready, busy, out_valid, product);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_reset_no_result: out_valid seen=1 required 0");
    end
    out_ready = 1'b0;
    op(4'h2, 4'h6, 8'h0C, 0, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] q[$];
    logic [2*W-1:0] exp;
    int acc_n = 0;
    int done_n = 0;
    int cyc = 0;
    while ((acc_n < 1000 || q.size() != 0) && cyc < 60000) begin
      in_valid = (acc_n < 1000) && ($urandom_range(1) == 0);
      a_s = W'($urandom);
      b_s = W'($urandom);
      out_ready = 1'($urandom);
      if (in_valid && in_ready) begin
        n_cmp++;
        if (q.size() != 0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_accept: pending=%0d busy=%b required 0/0",
                   q.size(), busy);
        end
        q.push_back(ref_mul(a_s, b_s));
        acc_n++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_dup: product=%h with no pending op", product);
        end else begin
          exp = q.pop_front();
          if (product !== exp) begin
            n_fail++;
            $display("FAIL b2b_product %0d: got %h required %h",
                     done_n, product, exp);
          end
        end
        done_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (acc_n != 1000 || done_n != 1000 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: accepted=%0d done=%0d pending=%0d required 1000/1000/0",
               acc_n, done_n, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
